// File: rtl/contador_pulsador_pkg.sv
// Shared types and constant helpers for the push-button counter.
//   estado_t    : button FSM states
//   clog2       : ceiling log2 for parameter sizing
//   timer_width : width of the hold/repeat timer
package contador_pulsador_pkg;

    typedef enum logic [2:0] {
        IDLE,
        UP_DELAY,
        UP_REPEAT,
        DN_DELAY,
        DN_REPEAT
    } estado_t;

    // Ceiling log2; 0 and 1 both need zero bits.
    function automatic int unsigned clog2(input int unsigned x);
        int unsigned r;
        int unsigned v;
        r = 0;
        if (x > 1) begin
            v = x - 1;
            while (v != 0) begin
                r = r + 1;
                v = v >> 1;
            end
        end
        return r;
    endfunction

    // Timer must hold values up to max(delay, period); never narrower than 1 bit.
    function automatic int unsigned timer_width(input int unsigned delay,
                                                input int unsigned period);
        int unsigned m;
        int unsigned w;
        m = (delay > period) ? delay : period;
        w = clog2(m + 1);
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/pulsador_repeat.sv
// Button FSM with hold-to-auto-repeat timer.
//   clk, rst   : clock, synchronous active-high reset
//   en         : freezes FSM and timer when low, suppresses steps
//   sb         : debounced buttons, sb[1] = up, sb[0] = down
//   step_up_c  : combinational one-cycle up-step request
//   step_dn_c  : combinational one-cycle down-step request
module pulsador_repeat
    import contador_pulsador_pkg::*;
#(
    parameter int unsigned REPEAT_DELAY  = 0,
    parameter int unsigned REPEAT_PERIOD = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] sb,
    output logic       step_up_c,
    output logic       step_dn_c
);

    localparam int unsigned   TW          = timer_width(REPEAT_DELAY, REPEAT_PERIOD);
    localparam bit            REPEAT_ON   = (REPEAT_DELAY != 0);
    localparam logic [TW-1:0] DELAY_LAST  = TW'((REPEAT_DELAY == 0) ? 0 : REPEAT_DELAY - 1);
    localparam logic [TW-1:0] PERIOD_LAST = TW'(REPEAT_PERIOD - 1);

    estado_t       state, state_nxt;
    logic [TW-1:0] timer, timer_nxt;

    // State and timer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            timer <= '0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
        end
    end

    // Next state and timer; everything holds while en is low
    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        if (en) begin
            case (state)
                IDLE: begin
                    if (sb[1]) begin
                        state_nxt = UP_DELAY;
                        timer_nxt = '0;
                    end else if (sb[0]) begin
                        state_nxt = DN_DELAY;
                        timer_nxt = '0;
                    end
                end
                UP_DELAY: begin
                    if (!sb[1]) begin
                        state_nxt = IDLE;
                    end else if (REPEAT_ON) begin
                        if (timer == DELAY_LAST) begin
                            state_nxt = UP_REPEAT;
                            timer_nxt = '0;
                        end else begin
                            timer_nxt = timer + TW'(1);
                        end
                    end
                end
                UP_REPEAT: begin
                    if (!sb[1]) begin
                        state_nxt = IDLE;
                    end else if (timer == PERIOD_LAST) begin
                        timer_nxt = '0;
                    end else begin
                        timer_nxt = timer + TW'(1);
                    end
                end
                DN_DELAY: begin
                    if (!sb[0]) begin
                        state_nxt = IDLE;
                    end else if (REPEAT_ON) begin
                        if (timer == DELAY_LAST) begin
                            state_nxt = DN_REPEAT;
                            timer_nxt = '0;
                        end else begin
                            timer_nxt = timer + TW'(1);
                        end
                    end
                end
                DN_REPEAT: begin
                    if (!sb[0]) begin
                        state_nxt = IDLE;
                    end else if (timer == PERIOD_LAST) begin
                        timer_nxt = '0;
                    end else begin
                        timer_nxt = timer + TW'(1);
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    timer_nxt = '0;
                end
            endcase
        end
    end

    // Step pulses: fire on the press itself and on each timer expiry
    always_comb begin
        step_up_c = 1'b0;
        step_dn_c = 1'b0;
        if (en) begin
            case (state)
                IDLE: begin
                    if (sb[1])      step_up_c = 1'b1;
                    else if (sb[0]) step_dn_c = 1'b1;
                end
                UP_DELAY:  step_up_c = sb[1] && REPEAT_ON && (timer == DELAY_LAST);
                UP_REPEAT: step_up_c = sb[1] && (timer == PERIOD_LAST);
                DN_DELAY:  step_dn_c = sb[0] && REPEAT_ON && (timer == DELAY_LAST);
                DN_REPEAT: step_dn_c = sb[0] && (timer == PERIOD_LAST);
                default: begin
                    step_up_c = 1'b0;
                    step_dn_c = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/contador_pulsador.sv
// Up/down push-button counter with range, wrap/saturate, auto-repeat and load.
//   clk, rst : clock, synchronous active-high reset
//   en       : enables button handling and stepping
//   sb       : debounced buttons, sb[1] = up, sb[0] = down
//   load     : synchronous load strobe (independent of en)
//   load_val : value to load, clamped into [MIN_VAL, MAX_VAL]
//   cuenta   : registered count
//   carry    : one-cycle pulse on MAX_VAL -> MIN_VAL wrap
//   borrow   : one-cycle pulse on MIN_VAL -> MAX_VAL wrap
module contador_pulsador
    import contador_pulsador_pkg::*;
#(
    parameter int unsigned WIDTH         = 4,
    parameter int unsigned MIN_VAL       = 0,
    parameter int unsigned MAX_VAL       = 8,
    parameter int unsigned SATURATE      = 0,
    parameter int unsigned REPEAT_DELAY  = 0,
    parameter int unsigned REPEAT_PERIOD = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       sb,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] cuenta,
    output logic             carry,
    output logic             borrow
);

    localparam logic [WIDTH-1:0] MIN_V = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VAL);

    logic             step_up_c, step_dn_c;
    logic [WIDTH-1:0] cuenta_nxt;
    logic             carry_nxt, borrow_nxt;

    pulsador_repeat #(
        .REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_pulsador (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .sb        (sb),
        .step_up_c (step_up_c),
        .step_dn_c (step_dn_c)
    );

    // Datapath: load beats step; wrap or saturate at range limits
    always_comb begin
        cuenta_nxt = cuenta;
        carry_nxt  = 1'b0;
        borrow_nxt = 1'b0;
        if (load) begin
            // "<=" rather than "<" keeps the compare meaningful when MIN_VAL is 0
            if (load_val > MAX_V)       cuenta_nxt = MAX_V;
            else if (load_val <= MIN_V) cuenta_nxt = MIN_V;
            else                        cuenta_nxt = load_val;
        end else if (step_up_c) begin
            if (cuenta < MAX_V) begin
                cuenta_nxt = cuenta + WIDTH'(1);
            end else if (SATURATE == 0) begin
                cuenta_nxt = MIN_V;
                carry_nxt  = 1'b1;
            end
        end else if (step_dn_c) begin
            if (cuenta > MIN_V) begin
                cuenta_nxt = cuenta - WIDTH'(1);
            end else if (SATURATE == 0) begin
                cuenta_nxt = MAX_V;
                borrow_nxt = 1'b1;
            end
        end
    end

    // Count and wrap-pulse registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cuenta <= MIN_V;
            carry  <= 1'b0;
            borrow <= 1'b0;
        end else begin
            cuenta <= cuenta_nxt;
            carry  <= carry_nxt;
            borrow <= borrow_nxt;
        end
    end

endmodule

// File: tb/tb_contador_pulsador.sv
// Self-checking bench: default, saturating and auto-repeat instances.
module tb_contador_pulsador;

    typedef struct packed {
        logic [3:0] cuenta;
        logic       carry;
        logic       borrow;
    } obs_t;

    logic       clk;
    logic       rst, en, load;
    logic [3:0] load_val;
    logic [1:0] sb_d, sb_s, sb_r;
    logic [3:0] cnt_d, cnt_s, cnt_r;
    logic       cy_d, cy_s, cy_r, bw_d, bw_s, bw_r;

    obs_t q_d[$];
    obs_t q_s[$];
    obs_t q_r[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Expected cuenta of the repeat instance: 10 held edges, release, then hold with en dropped
    localparam int REP_EXP [22] = '{1,1,1,1,2,2,3,3,4,4,4, 5,5,5,5,5,5,5,6,6,7,7};

    contador_pulsador u_def (
        .clk(clk), .rst(rst), .en(en), .sb(sb_d), .load(load), .load_val(load_val),
        .cuenta(cnt_d), .carry(cy_d), .borrow(bw_d)
    );

    contador_pulsador #(.SATURATE(1)) u_sat (
        .clk(clk), .rst(rst), .en(en), .sb(sb_s), .load(load), .load_val(load_val),
        .cuenta(cnt_s), .carry(cy_s), .borrow(bw_s)
    );

    contador_pulsador #(.REPEAT_DELAY(4), .REPEAT_PERIOD(2)) u_rep (
        .clk(clk), .rst(rst), .en(en), .sb(sb_r), .load(load), .load_val(load_val),
        .cuenta(cnt_r), .carry(cy_r), .borrow(bw_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t mk(input int v, input bit c, input bit b);
        obs_t o;
        o.cuenta = 4'(v);
        o.carry  = c;
        o.borrow = b;
        return o;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        obs_t e, g;
        rst = 1'b1;
        sb_d = 2'b11; sb_s = 2'b11; sb_r = 2'b11;
        for (int i = 0; i < 2; i++) begin
            q_d.push_back(mk(0, 0, 0));
            q_s.push_back(mk(0, 0, 0));
            q_r.push_back(mk(0, 0, 0));
            tick();
            e = q_d.pop_front(); g = {cnt_d, cy_d, bw_d}; n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL reset_def[%0d]: cuenta=%0d carry=%b borrow=%b, required cuenta=%0d carry=%b borrow=%b",
                         i, g.cuenta, g.carry, g.borrow, e.cuenta, e.carry, e.borrow);
            end
            e = q_s.pop_front(); g = {cnt_s, cy_s, bw_s}; n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL reset_sat[%0d]: cuenta=%0d carry=%b borrow=%b, required cuenta=%0d carry=%b borrow=%b",
                         i, g.cuenta, g.carry, g.borrow, e.cuenta, e.carry, e.borrow);
            end
            e = q_r.pop_front(); g = {cnt_r, cy_r, bw_r}; n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL reset_rep[%0d]: cuenta=%0d carry=%b borrow=%b, required cuenta=%0d carry=%b borrow=%b",
                         i, g.cuenta, g.carry, g.borrow, e.cuenta, e.carry, e.borrow);
            end
        end
        rst = 1'b0;
        sb_d = 2'b00; sb_s = 2'b00; sb_r = 2'b00;
    endtask

    // Held press counts once; then eight single-cycle presses wrap 8 -> 0 with carry
    task automatic test_single_press();
        obs_t e, g;
        int   p;
        en = 1'b1;
        for (int i = 0; i < 22; i++) begin
            if (i < 5)       sb_d = 2'b10;
            else if (i == 5) sb_d = 2'b00;
            else             sb_d = (i % 2 == 0) ? 2'b10 : 2'b00;
            p = (i < 6) ? 1 : (i - 6) / 2 + 2;
            q_d.push_back(mk(p % 9, (i >= 6) && (i % 2 == 0) && (p == 9), 0));
            tick();
            e = q_d.pop_front(); g = {cnt_d, cy_d, bw_d}; n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL single_press[%0d]: cuenta=%0d carry=%b borrow=%b, required cuenta=%0d carry=%b borrow=%b",
                         i, g.cuenta, g.carry, g.borrow, e.cuenta, e.carry, e.borrow);
            end
        end
    endtask

    // Down from MIN: wrap with borrow, or hold when saturating
    task automatic test_down_wrap();
        obs_t e, g;
        for (int i = 0; i < 2; i++) begin
            sb_d = (i == 0) ? 2'b01 : 2'b00;
            sb_s = sb_d;
            q_d.push_back(mk(8, 0, i == 0));
            q_s.push_back(mk(0, 0, 0));
            tick();
            e = q_d.pop_front(); g = {cnt_d, cy_d, bw_d}; n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL down_wrap[%0d]: cuenta=%0d carry=%b borrow=%b, required cuenta=%0d carry=%b borrow=%b",
                         i, g.cuenta, g.carry, g.borrow, e.cuenta, e.carry, e.borrow);
            end
            e = q_s.pop_front(); g = {cnt_s, cy_s, bw_s}; n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL down_saturate[%0d]: cuenta=%0d carry=%b borrow=%b, required cuenta=%0d carry=%b borrow=%b",
                         i, g.cuenta, g.carry, g.borrow, e.cuenta, e.carry, e.borrow);
            end
        end
    endtask

    // Auto-repeat cadence, then en dropped for 3 cycles mid-hold
    task automatic test_auto_repeat();
        obs_t e, g;
        for (int i = 0; i < 22; i++) begin
            sb_r = (i == 10 || i == 21) ? 2'b00 : 2'b10;
            en   = (i >= 14 && i <= 16) ? 1'b0 : 1'b1;
            q_r.push_back(mk(REP_EXP[i], 0, 0));
            tick();
            e = q_r.pop_front(); g = {cnt_r, cy_r, bw_r}; n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL auto_repeat[%0d]: cuenta=%0d carry=%b borrow=%b, required cuenta=%0d carry=%b borrow=%b",
                         i, g.cuenta, g.carry, g.borrow, e.cuenta, e.carry, e.borrow);
            end
        end
        en = 1'b1;
    endtask

    // Up wins from IDLE; opposite button acted on one edge after release
    task automatic test_simultaneous();
        obs_t e, g;
        logic [1:0] sb_tab [4];
        obs_t       ex_tab [4];
        sb_tab = '{2'b11, 2'b01, 2'b01, 2'b00};
        ex_tab = '{mk(0, 1, 0), mk(0, 0, 0), mk(8, 0, 1), mk(8, 0, 0)};
        for (int i = 0; i < 4; i++) begin
            sb_d = sb_tab[i];
            q_d.push_back(ex_tab[i]);
            tick();
            e = q_d.pop_front(); g = {cnt_d, cy_d, bw_d}; n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL simultaneous[%0d]: cuenta=%0d carry=%b borrow=%b, required cuenta=%0d carry=%b borrow=%b",
                         i, g.cuenta, g.carry, g.borrow, e.cuenta, e.carry, e.borrow);
            end
        end
    endtask

    // Load ignores en, clamps, and overrides a same-cycle step
    task automatic test_load();
        obs_t e, g;
        logic       en_tab [6];
        logic       ld_tab [6];
        logic [3:0] lv_tab [6];
        logic [1:0] sb_tab [6];
        int         ex_tab [6];
        en_tab = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        ld_tab = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        lv_tab = '{4'd3, 4'd12, 4'd3, 4'd0, 4'd0, 4'd0};
        sb_tab = '{2'b00, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00};
        ex_tab = '{3, 8, 3, 3, 4, 4};
        for (int i = 0; i < 6; i++) begin
            en = en_tab[i]; load = ld_tab[i]; load_val = lv_tab[i]; sb_d = sb_tab[i];
            q_d.push_back(mk(ex_tab[i], 0, 0));
            if (i < 2) q_s.push_back(mk(ex_tab[i], 0, 0));
            tick();
            e = q_d.pop_front(); g = {cnt_d, cy_d, bw_d}; n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL load[%0d]: cuenta=%0d carry=%b borrow=%b, required cuenta=%0d carry=%b borrow=%b",
                         i, g.cuenta, g.carry, g.borrow, e.cuenta, e.carry, e.borrow);
            end
            if (q_s.size() != 0) begin
                e = q_s.pop_front(); g = {cnt_s, cy_s, bw_s}; n_checks++;
                if (g !== e) begin
                    n_fail++;
                    $display("FAIL load_sat[%0d]: cuenta=%0d carry=%b borrow=%b, required cuenta=%0d carry=%b borrow=%b",
                             i, g.cuenta, g.carry, g.borrow, e.cuenta, e.carry, e.borrow);
                end
            end
        end
        en = 1'b1; load = 1'b0;
    endtask

    // Saturating instance holds at MAX without carry
    task automatic test_saturate_up();
        obs_t e, g;
        for (int i = 0; i < 5; i++) begin
            load     = (i == 0);
            load_val = 4'd7;
            sb_s     = (i == 1 || i == 3) ? 2'b10 : 2'b00;
            q_s.push_back(mk((i == 0) ? 7 : 8, 0, 0));
            tick();
            e = q_s.pop_front(); g = {cnt_s, cy_s, bw_s}; n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL saturate_up[%0d]: cuenta=%0d carry=%b borrow=%b, required cuenta=%0d carry=%b borrow=%b",
                         i, g.cuenta, g.carry, g.borrow, e.cuenta, e.carry, e.borrow);
            end
        end
        load = 1'b0;
    endtask

    // Reset during a hold: the still-held button counts as a new press afterwards
    task automatic test_reset_mid_hold();
        obs_t e, g;
        int   ex_tab [5];
        ex_tab = '{8, 8, 0, 1, 1};
        for (int i = 0; i < 5; i++) begin
            rst  = (i == 2);
            sb_d = (i == 4) ? 2'b00 : 2'b10;
            q_d.push_back(mk(ex_tab[i], 0, 0));
            tick();
            e = q_d.pop_front(); g = {cnt_d, cy_d, bw_d}; n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL reset_mid_hold[%0d]: cuenta=%0d carry=%b borrow=%b, required cuenta=%0d carry=%b borrow=%b",
                         i, g.cuenta, g.carry, g.borrow, e.cuenta, e.carry, e.borrow);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; load = 1'b0; load_val = 4'd0;
        sb_d = 2'b00; sb_s = 2'b00; sb_r = 2'b00;
        test_reset();
        test_single_press();
        test_down_wrap();
        test_auto_repeat();
        test_simultaneous();
        test_load();
        test_saturate_up();
        test_reset_mid_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
